// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM states, opcodes,
// ALU operation encodings, datapath select encodings and the control word.
package multicycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXECUTE,
      ALUWB,
      BEQ,
      ADDIEX,
      ADDIWB,
      JUMP
   } stateT;

   // Primary opcodes taken from instr[31:26]
   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_J     = 6'b000010,
      OP_BEQ   = 6'b000100,
      OP_ADDI  = 6'b001000,
      OP_LW    = 6'b100011,
      OP_SW    = 6'b101011
   } opcodeT;

   // aluOp as seen by the ALU decoder; the ALU decoder uses this same type
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluOpT;

   // Second ALU operand: register B, constant 4, sign-extended immediate,
   // or the shifted immediate used for the branch target
   typedef enum logic [1:0] {
      SRCB_REG    = 2'b00,
      SRCB_FOUR   = 2'b01,
      SRCB_IMM    = 2'b10,
      SRCB_BRANCH = 2'b11
   } srcBT;

   // Next PC: ALU result, registered ALU result (branch target), jump target
   typedef enum logic [1:0] {
      PCSRC_ALU    = 2'b00,
      PCSRC_TARGET = 2'b01,
      PCSRC_JUMP   = 2'b10
   } pcSrcT;

   // Raw per-state control word, before any mem_ready/zero qualification
   typedef struct packed {
      logic       memReq;
      logic       iOrD;
      logic       irWrite;
      logic       pcWrite;
      logic       branch;
      logic       regDst;
      logic       memToReg;
      logic       regWrite;
      logic       memWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSrc;
      logic [1:0] aluOp;
   } ctrlWordT;

   // True for every opcode the controller knows how to sequence
   function automatic logic isSupported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_output_decoder.sv
// Pure state-to-control-word map for the multicycle controller. Strobes that
// depend on mem_ready or zero are emitted unqualified; the top gates them.
import multicycle_control_pkg::*;

module mc_output_decoder (
   input  stateT    i_state,
   output ctrlWordT o_ctrl
);

   // Map each FSM state to its raw control word; anything unlisted stays 0
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         FETCH: begin
            o_ctrl.memReq  = 1'b1;
            o_ctrl.irWrite = 1'b1;
            o_ctrl.pcWrite = 1'b1;
            o_ctrl.aluSrcB = SRCB_FOUR;
            o_ctrl.aluOp   = ALUOP_ADD;
            o_ctrl.pcSrc   = PCSRC_ALU;
         end
         DECODE: begin
            o_ctrl.aluSrcB = SRCB_BRANCH;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         MEMADR: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         MEMRD: begin
            o_ctrl.memReq = 1'b1;
            o_ctrl.iOrD   = 1'b1;
         end
         MEMWB: begin
            o_ctrl.memToReg = 1'b1;
            o_ctrl.regWrite = 1'b1;
         end
         MEMWR: begin
            o_ctrl.memReq   = 1'b1;
            o_ctrl.iOrD     = 1'b1;
            o_ctrl.memWrite = 1'b1;
         end
         EXECUTE: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_REG;
            o_ctrl.aluOp   = ALUOP_FUNCT;
         end
         ALUWB: begin
            o_ctrl.regDst   = 1'b1;
            o_ctrl.regWrite = 1'b1;
         end
         BEQ: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_REG;
            o_ctrl.aluOp   = ALUOP_SUB;
            o_ctrl.pcSrc   = PCSRC_TARGET;
            o_ctrl.branch  = 1'b1;
         end
         ADDIEX: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         ADDIWB: begin
            o_ctrl.regWrite = 1'b1;
         end
         JUMP: begin
            o_ctrl.pcSrc   = PCSRC_JUMP;
            o_ctrl.pcWrite = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style main controller. Sequences fetch/decode/execute
// states, holds on memory handshakes and qualifies PC and IR strobes.
import multicycle_control_pkg::*;

module multicycle_control (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       iOrD,
   output logic       irWrite,
   output logic       regDst,
   output logic       memToReg,
   output logic       regWrite,
   output logic       memWrite,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] pcSrc,
   output logic [1:0] aluOp,
   output logic       pcEn,
   output logic       illegal_op
);

   stateT      r_state;
   stateT      w_nextState;
   logic [5:0] r_opcode;
   logic       r_run;
   ctrlWordT   w_rawCtrl;
   ctrlWordT   w_ctrl;

   // r_run stays low through reset so the first FETCH starts on the first
   // clock edge after release, not while reset is still being deasserted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FETCH;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_run   <= 1'b1;
      end
   end

   // Capture the opcode in DECODE so MEMADR routes on a stable value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opcode <= 6'b000000;
      end else if (r_state == DECODE) begin
         r_opcode <= opcode;
      end
   end

   // Next-state selection; only FETCH/MEMRD/MEMWR look at mem_ready
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         FETCH: begin
            if (r_run && mem_ready) w_nextState = DECODE;
         end
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_nextState = MEMADR;
               OP_RTYPE:     w_nextState = EXECUTE;
               OP_BEQ:       w_nextState = BEQ;
               OP_ADDI:      w_nextState = ADDIEX;
               OP_J:         w_nextState = JUMP;
               default:      w_nextState = FETCH;
            endcase
         end
         MEMADR:  w_nextState = (r_opcode == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   w_nextState = mem_ready ? MEMWB : MEMRD;
         MEMWB:   w_nextState = FETCH;
         MEMWR:   w_nextState = mem_ready ? FETCH : MEMWR;
         EXECUTE: w_nextState = ALUWB;
         ALUWB:   w_nextState = FETCH;
         BEQ:     w_nextState = FETCH;
         ADDIEX:  w_nextState = ADDIWB;
         ADDIWB:  w_nextState = FETCH;
         JUMP:    w_nextState = FETCH;
         default: w_nextState = FETCH;
      endcase
   end

   mc_output_decoder u_outputDecoder (
      .i_state (r_state),
      .o_ctrl  (w_rawCtrl)
   );

   // Qualify fetch strobes with mem_ready, silence everything until running,
   // and form pcEn from the unconditional and branch-taken PC writes
   always_comb begin
      w_ctrl = w_rawCtrl;
      if (r_state == FETCH) begin
         w_ctrl.irWrite = w_rawCtrl.irWrite & mem_ready;
         w_ctrl.pcWrite = w_rawCtrl.pcWrite & mem_ready;
      end
      if (!r_run) begin
         w_ctrl = '0;
      end
      mem_req    = w_ctrl.memReq;
      iOrD       = w_ctrl.iOrD;
      irWrite    = w_ctrl.irWrite;
      regDst     = w_ctrl.regDst;
      memToReg   = w_ctrl.memToReg;
      regWrite   = w_ctrl.regWrite;
      memWrite   = w_ctrl.memWrite;
      aluSrcA    = w_ctrl.aluSrcA;
      aluSrcB    = w_ctrl.aluSrcB;
      pcSrc      = w_ctrl.pcSrc;
      aluOp      = w_ctrl.aluOp;
      pcEn       = w_ctrl.pcWrite | (w_ctrl.branch & zero);
      illegal_op = r_run & (r_state == DECODE) & ~isSupported(opcode);
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; port names clk and rst_n.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 opcode  in  6  instr[31:26], sampled in DECODE.
REQ-005 zero  in  1  ALU zero flag, used in BEQ.
REQ-006 mem_ready  in  1  memory done; completes the current access in the same cycle.
REQ-007 mem_req  out  1  memory access request.
REQ-008 iOrD, irWrite, regDst, memToReg, regWrite, memWrite, aluSrcA  out  1 each  datapath strobes and selects.
REQ-009 aluSrcB, pcSrc  out  2 each  datapath selects.
REQ-010 aluOp  out  2  to the ALU decoder: 00 add, 01 subtract, 10 use funct.
REQ-011 pcEn  out  1  PC load enable.
REQ-012 illegal_op  out  1  one-cycle pulse on an unsupported opcode.

Function
REQ-013 FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BEQ, ADDIEX, ADDIWB, JUMP.
REQ-014 Opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
REQ-015 FETCH: mem_req=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite=1 and pcWrite=1 only when mem_ready=1.
  - Hold FETCH while mem_ready=0; otherwise go to DECODE.
REQ-016 DECODE: aluSrcA=0, aluSrcB=11, aluOp=00.
  - Next state: lw/sw->MEMADR, R->EXECUTE, beq->BEQ, addi->ADDIEX, j->JUMP.
  - Any other opcode: illegal_op=1 and go to FETCH.
REQ-017 MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00; lw->MEMRD, sw->MEMWR.
  - The opcode SHALL be registered in DECODE so a change on opcode after DECODE is ignored.
REQ-018 MEMRD: mem_req=1, iOrD=1; hold until mem_ready, then MEMWB.
REQ-019 MEMWB: regDst=0, memToReg=1, regWrite=1; then FETCH.
REQ-020 MEMWR: mem_req=1, iOrD=1, memWrite=1; hold until mem_ready, then FETCH.
REQ-021 EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10; then ALUWB.
REQ-022 ALUWB: regDst=1, memToReg=0, regWrite=1; then FETCH.
REQ-023 BEQ: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch=1; then FETCH.
REQ-024 ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00; then ADDIWB.
REQ-025 ADDIWB: regDst=0, memToReg=0, regWrite=1; then FETCH.
REQ-026 JUMP: pcSrc=10, pcWrite=1; then FETCH.
REQ-027 pcEn SHALL equal pcWrite OR (branch AND zero), evaluated combinationally in the same cycle.
REQ-028 Any output not listed for a state SHALL be 0 in that state.
REQ-029 Instruction latency with mem_ready tied high:
  - beq and j: 3 cycles.
  - R, addi and sw: 4 cycles.
  - lw: 5 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
REQ-030 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-031 Asserting rst_n=0 SHALL force FETCH immediately, including mid-instruction; the registered opcode SHALL clear to 0.
REQ-032 While rst_n=0, mem_req, irWrite, pcEn, memWrite, regWrite and illegal_op SHALL be 0.
REQ-033 The first FETCH SHALL begin on the first rising clk edge after rst_n is released.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the opcode constants and the aluOp encodings; the ALU decoder SHALL reuse the aluOp encodings.
REQ-035 One sub-module SHALL be used: mc_output_decoder, a purely combinational map from state to control word.
  - The mem_ready/zero gating SHALL stay in the top module.

Verification
REQ-036 lw, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regWrite=1 and memToReg=1 in cycle 5.
REQ-037 sw with mem_ready low for 3 cycles in MEMWR -> memWrite=1 for 4 cycles; FETCH follows.
REQ-038 beq with zero=1 -> pcEn=1 and pcSrc=01 in BEQ; with zero=0 -> pcEn=0.
REQ-039 opcode 111111 -> illegal_op=1 for exactly 1 cycle in DECODE; FETCH next cycle; no regWrite or memWrite.
REQ-040 rst_n pulsed low during MEMRD -> strobes 0 immediately; FETCH after release; no MEMWB.
REQ-041 R-type, mem_ready=1 -> aluOp=10 in EXECUTE; regDst=1 and regWrite=1 in ALUWB; total 4 cycles.
